nand_page_xfer_ctrl: RTL and testbench
======================================

Name: nand_page_xfer_ctrl

Overview:
- Byte-stream transfer sequencer that sits directly upstream of the 2048x8 page buffer RAM and owns its host-side port (port A).
- On a start command it moves `len` bytes, beginning at column `col`, in one of two directions:
  - write: host byte stream into the buffer;
  - read: buffer into a host byte stream.
- Column auto-increments each byte. The block hides the buffer's 1-cycle registered read latency behind a valid/ready stream.
- Used by the NAND model for data-in (80h/85h) and data-out (05h/E0h) phases.

Parameters:
- ADDR_W, 11, buffer address width
- DATA_W, 8, byte width
- PAGE_BYTES, 2048, buffer depth; legal columns 0..PAGE_BYTES-1

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- dir  in  1  0 = write into buffer, 1 = read from buffer
- col  in  ADDR_W  start column
- len  in  ADDR_W+1  byte count, 0..PAGE_BYTES
- abort  in  1  synchronous cancel of the active transfer
- busy  out  1  high whenever not in IDLE
- done  out  1  1-cycle pulse at end of transfer, error or abort
- err  out  1  valid only with done: range error or abort
- wr_data  in  DATA_W  write-stream byte
- wr_valid  in  1  write-stream valid
- wr_ready  out  1  write-stream ready
- rd_data  out  DATA_W  read-stream byte
- rd_valid  out  1  read-stream valid
- rd_ready  in  1  read-stream ready
- buf_addr  out  ADDR_W  to RAM addr_a
- buf_wdata  out  DATA_W  to RAM data_a
- buf_we  out  1  to RAM we_a
- buf_en  out  1  to RAM clk_en_a
- buf_rdata  in  DATA_W  from RAM OutA; valid the cycle after a read is issued

Behaviour:
- Reset (asynchronous, active-low):
  - state to IDLE; all outputs 0; column and remaining counters 0; read FIFO flushed.
  - An in-flight transfer is dropped with no done pulse. No buffer write occurs while reset_n = 0.
- States: IDLE, WRITE, READ, FINISH.
- IDLE, on start = 1:
  - Latch col, len and dir.
  - If col + len > PAGE_BYTES (evaluated with ADDR_W+1 bits, no wrap): go to FINISH with err = 1. Nothing is transferred.
  - Else if len = 0: go to FINISH with err = 0.
  - Else: go to WRITE or READ according to dir.
- start is ignored while busy.
- WRITE:
  - wr_ready = 1.
  - Each cycle with wr_valid & wr_ready, combinationally drive buf_en = 1, buf_we = 1, buf_addr = cur_col, buf_wdata = wr_data. The byte lands at that edge.
  - cur_col increments and remaining decrements on each accepted byte.
  - After the byte that brings remaining to 0, go to FINISH. wr_ready is 0 from the next cycle on.
  - Sustained throughput is 1 byte/clk.
- READ:
  - Output is a 2-entry FIFO; rd_valid = FIFO not empty; rd_data = FIFO head.
  - A read is issued (buf_en = 1, buf_we = 0, buf_addr = cur_col) when issued_remaining > 0 and (FIFO occupancy + in-flight reads) < 2.
  - buf_rdata is pushed into the FIFO on the edge after the issue edge.
  - A pop occurs on rd_valid & rd_ready.
  - Latency: start sampled at edge E0, first read issued at E1, first rd_valid high after E2.
  - With rd_ready held high, throughput is 1 byte/clk.
  - With rd_ready = 0, rd_data and rd_valid hold. No bytes are lost and none are duplicated.
  - Go to FINISH when the last byte is popped.
- FINISH: done = 1 for exactly one cycle, err as determined; then IDLE. busy falls with done.
- abort in WRITE or READ:
  - Takes effect at the next edge: go to FINISH with err = 1; FIFO flushed.
  - A write accepted in the same cycle as abort is still committed.
  - abort in IDLE or FINISH has no effect.
- buf_en = 0 in IDLE and FINISH. buf_we is never 1 outside WRITE.
- The final byte uses column col + len - 1 ≤ PAGE_BYTES - 1. The column counter never wraps within a legal transfer.

Test Plan:
- Write then read back:
  - Write col = 0, len = 2048, bytes i & 0xFF with wr_valid held high → 2048 buffer writes at 1 byte/clk, done after the last byte, err = 0.
  - Read col = 0, len = 2048 with rd_ready high → same bytes in order; first rd_valid 2 cycles after start.
- Read backpressure:
  - Read col = 100, len = 10 with rd_ready toggling 1/0 and held 0 for 5 cycles → bytes for columns 100..109 exactly once each, in order; rd_data stable while stalled; never more than 2 reads outstanding.
- Edge of page:
  - Write col = 2047, len = 1, byte 0xA5 → single write at address 2047, done, err = 0.
  - Write col = 2047, len = 2 → done with err = 1 on the cycle after FINISH entry, buf_we never asserted.
- Zero length and ignored start:
  - len = 0 → done pulse with err = 0, no buffer activity.
  - start pulsed during busy → ignored; the transfer in progress completes normally.
- Abort:
  - Write col = 0, len = 16; abort after 5 bytes → columns 0..4 (plus any byte accepted in the abort cycle) written, done with err = 1, wr_ready = 0 thereafter.
  - Read abort → FIFO emptied, rd_valid = 0.
- Reset mid-read:
  - reset_n low asynchronously during a read of len = 64 → busy, rd_valid, done and buf_en go to 0 immediately.
  - After release, a new read col = 0, len = 4 returns correct data.

Source files
------------

// File: rtl/nand_page_xfer_ctrl_if.sv
// Host command, byte streams and page-buffer port A of the page transfer sequencer.
interface nand_page_xfer_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  // command / status
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err;

  // host write stream (into the buffer)
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  // host read stream (out of the buffer)
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  // page buffer port A
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              buf_we;
  logic              buf_en;
  logic [DATA_W-1:0] buf_rdata;

  // Host plus RAM side: issues commands, sources/sinks streams, returns RAM read data
  modport master (
    output start, dir, col, len, abort, wr_data, wr_valid, rd_ready, buf_rdata,
    input  busy, done, err, wr_ready, rd_data, rd_valid, buf_addr, buf_wdata, buf_we, buf_en
  );

  // Sequencer side
  modport slave (
    input  start, dir, col, len, abort, wr_data, wr_valid, rd_ready, buf_rdata,
    output busy, done, err, wr_ready, rd_data, rd_valid, buf_addr, buf_wdata, buf_we, buf_en
  );
endinterface

// File: rtl/nand_page_xfer_ctrl.sv
// Page buffer transfer sequencer: moves len bytes starting at col between a
// host valid/ready byte stream and port A of the page buffer RAM. Reads are
// staged through a 2-entry FIFO that hides the RAM's registered read latency.
module nand_page_xfer_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int PAGE_BYTES = 2048
) (
  input logic                  clk,
  input logic                  reset_n,
  nand_page_xfer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   PAGE_LIMIT = (ADDR_W+1)'(PAGE_BYTES);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] COL_ONE    = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] cur_col;
  logic [ADDR_W:0]   remaining;        // bytes still to accept (write) or to pop (read)
  logic [ADDR_W:0]   issue_remaining;  // buffer reads not yet issued
  logic              busy_state;
  logic              done_pulse;
  logic              err_flag;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wr_ptr;
  logic              fifo_rd_ptr;
  logic [1:0]        fifo_count;
  logic [1:0]        fifo_count_next;
  logic              read_inflight;    // a read was issued last cycle; its data is on buf_rdata now

  logic [ADDR_W:0]   col_end;
  logic              wr_fire;
  logic              rd_issue;
  logic              rd_pop;
  logic              rd_avail;

  // Handshakes and read throttle. A read may issue when the FIFO occupancy
  // after this edge (pending push in, pop out) leaves room for it, which keeps
  // occupancy + in-flight at most 2 and still sustains one byte per clock.
  always_comb begin
    col_end         = {1'b0, bus.col} + bus.len;
    rd_avail        = (fifo_count != 2'd0);
    wr_fire         = (state == WRITE) && bus.wr_valid;
    rd_pop          = (state == READ) && rd_avail && bus.rd_ready;
    fifo_count_next = fifo_count + {1'b0, read_inflight} - {1'b0, rd_pop};
    rd_issue        = (state == READ) && (issue_remaining != '0) && (fifo_count_next < 2'd2);
  end

  assign bus.busy      = busy_state;
  assign bus.done      = done_pulse;
  assign bus.err       = err_flag;
  assign bus.wr_ready  = (state == WRITE);
  assign bus.rd_valid  = rd_avail;
  assign bus.rd_data   = rd_avail ? fifo_mem[fifo_rd_ptr] : '0;
  assign bus.buf_en    = wr_fire | rd_issue;
  assign bus.buf_we    = wr_fire;
  assign bus.buf_addr  = cur_col;
  assign bus.buf_wdata = wr_fire ? bus.wr_data : '0;

  // Transfer FSM with registered status, column/count tracking and read FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cur_col         <= '0;
      remaining       <= '0;
      issue_remaining <= '0;
      busy_state      <= 1'b0;
      done_pulse      <= 1'b0;
      err_flag        <= 1'b0;
      fifo_wr_ptr     <= 1'b0;
      fifo_rd_ptr     <= 1'b0;
      fifo_count      <= 2'd0;
      read_inflight   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      done_pulse    <= 1'b0;
      read_inflight <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cur_col         <= bus.col;
            remaining       <= bus.len;
            issue_remaining <= bus.len;
            busy_state      <= 1'b1;
            if (col_end > PAGE_LIMIT) begin
              // would run off the end of the page: refuse without touching the buffer
              state      <= FINISH;
              done_pulse <= 1'b1;
              err_flag   <= 1'b1;
            end else if (bus.len == '0) begin
              state      <= FINISH;
              done_pulse <= 1'b1;
              err_flag   <= 1'b0;
            end else begin
              state <= bus.dir ? READ : WRITE;
            end
          end
        end

        WRITE: begin
          if (wr_fire) begin
            cur_col   <= cur_col + COL_ONE;
            remaining <= remaining - CNT_ONE;
          end
          // a byte offered alongside abort has already been written this cycle
          if (bus.abort) begin
            state      <= FINISH;
            done_pulse <= 1'b1;
            err_flag   <= 1'b1;
          end else if (wr_fire && (remaining == CNT_ONE)) begin
            state      <= FINISH;
            done_pulse <= 1'b1;
            err_flag   <= 1'b0;
          end
        end

        READ: begin
          if (rd_issue) begin
            cur_col         <= cur_col + COL_ONE;
            issue_remaining <= issue_remaining - CNT_ONE;
          end
          if (read_inflight) begin
            fifo_mem[fifo_wr_ptr] <= bus.buf_rdata;
            fifo_wr_ptr           <= ~fifo_wr_ptr;
          end
          if (rd_pop) begin
            fifo_rd_ptr <= ~fifo_rd_ptr;
            remaining   <= remaining - CNT_ONE;
          end
          fifo_count    <= fifo_count_next;
          read_inflight <= rd_issue;
          if (bus.abort || (rd_pop && (remaining == CNT_ONE))) begin
            state         <= FINISH;
            done_pulse    <= 1'b1;
            err_flag      <= bus.abort;
            fifo_count    <= 2'd0;
            fifo_wr_ptr   <= 1'b0;
            fifo_rd_ptr   <= 1'b0;
            read_inflight <= 1'b0;
          end
        end

        FINISH: begin
          state      <= IDLE;
          busy_state <= 1'b0;
          err_flag   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand_page_xfer_ctrl.sv
// Self-checking bench for nand_page_xfer_ctrl: a behavioural 2048x8 RAM with
// registered read sits on port A; expected writes and read bytes are queued
// when stimulus is driven and compared as the DUT produces them.
module tb_nand_page_xfer_ctrl;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int PAGE   = 2048;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  nand_page_xfer_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  nand_page_xfer_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PAGE_BYTES(PAGE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // page buffer model, 1-cycle registered read
  logic [7:0] ram [PAGE];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (bus.buf_en) begin
      if (bus.buf_we) ram[bus.buf_addr] <= bus.buf_wdata;
      ram_q <= ram[bus.buf_addr];
    end
  end
  assign bus.buf_rdata = ram_q;

  int checks = 0;
  int failures = 0;
  logic [7:0]  model [PAGE];
  logic [7:0]  rd_exp_q [$];
  logic [18:0] wr_exp_q [$];
  int wr_count = 0;
  int en_count = 0;
  int rd_issued = 0;
  int rd_popped = 0;
  bit stall_en = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // port/stream monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.buf_en) en_count++;
      if (bus.buf_en && bus.buf_we) begin
        wr_count++;
        check_eq("we_only_in_write", bus.wr_ready, 1);
        check_eq("wr_pending", wr_exp_q.size() != 0, 1);
        if (wr_exp_q.size() != 0)
          check_eq("wr_addr_data", {bus.buf_addr, bus.buf_wdata}, wr_exp_q.pop_front());
      end
      if (bus.buf_en && !bus.buf_we) begin
        check_eq("rd_outstanding_le2",
                 (rd_issued + 1 - rd_popped - int'(bus.rd_valid && bus.rd_ready)) <= 2, 1);
        rd_issued++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        rd_popped++;
        check_eq("rd_pending", rd_exp_q.size() != 0, 1);
        if (rd_exp_q.size() != 0) check_eq("rd_data", bus.rd_data, rd_exp_q.pop_front());
      end
      if (stall_en && prev_stall) begin
        check_eq("rd_hold_valid", bus.rd_valid, 1);
        check_eq("rd_hold_data", bus.rd_data, prev_data);
      end
      prev_stall = stall_en && bus.rd_valid && !bus.rd_ready;
      prev_data  = bus.rd_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic do_write(input int c, input int l, input logic [7:0] key,
                          input int abort_at, input bit poke_start);
    int n;
    bit aborted;
    logic [10:0] a;
    logic [7:0] b;
    n = 0;
    aborted = 0;
    wr_count = 0;
    @(posedge clk); #1;
    bus.start = 1; bus.dir = 0; bus.col = ADDR_W'(c); bus.len = (ADDR_W+1)'(l);
    @(posedge clk); #1;
    bus.start = 0;
    for (int i = 0; i < l && !aborted; i++) begin
      a = 11'(c + i);
      b = 8'(c + i) ^ key;
      bus.wr_data = b;
      bus.wr_valid = 1;
      wr_exp_q.push_back({a, b});
      model[a] = b;
      if (i == abort_at) begin
        bus.abort = 1;
        aborted = 1;
      end
      if (poke_start && i == 2) begin
        bus.start = 1; bus.dir = 1; bus.col = '0; bus.len = '0;
      end
      @(posedge clk); #1;
      bus.abort = 0;
      bus.start = 0;
      n++;
    end
    bus.wr_valid = 0;
    check_eq("wr_done", bus.done, 1);
    check_eq("wr_err", bus.err, aborted);
    check_eq("wr_ready_after", bus.wr_ready, 0);
    check_eq("wr_count", wr_count, n);
    check_eq("wr_q_drained", wr_exp_q.size(), 0);
    $display("write col=%0d len=%0d bytes=%0d done=%0b err=%0b", c, l, wr_count, bus.done, bus.err);
    wr_exp_q.delete();
    @(posedge clk); #1;
    check_eq("wr_idle_busy", bus.busy, 0);
    check_eq("wr_idle_done", bus.done, 0);
  endtask

  task automatic do_short(input int c, input int l, input bit exp_err);
    en_count = 0;
    @(posedge clk); #1;
    bus.start = 1; bus.dir = 0; bus.col = ADDR_W'(c); bus.len = (ADDR_W+1)'(l);
    @(posedge clk); #1;
    bus.start = 0;
    check_eq("short_done", bus.done, 1);
    check_eq("short_err", bus.err, exp_err);
    check_eq("short_busy", bus.busy, 1);
    $display("short col=%0d len=%0d done=%0b err=%0b", c, l, bus.done, bus.err);
    @(posedge clk); #1;
    check_eq("short_idle_busy", bus.busy, 0);
    check_eq("short_idle_done", bus.done, 0);
    check_eq("short_no_buf_activity", en_count, 0);
  endtask

  // mode 0: rd_ready high, 1: toggling with a 5-cycle stall, 2: rd_ready low
  task automatic do_read(input int c, input int l, input int mode, input int abort_at, input bit timed);
    int cyc;
    bit got_done;
    bit aborted;
    cyc = 0;
    got_done = 0;
    aborted = 0;
    for (int i = 0; i < l; i++) rd_exp_q.push_back(model[11'(c + i)]);
    rd_issued = 0;
    rd_popped = 0;
    stall_en = 1;
    @(posedge clk); #1;
    bus.start = 1; bus.dir = 1; bus.col = ADDR_W'(c); bus.len = (ADDR_W+1)'(l);
    bus.rd_ready = (mode == 0);
    @(posedge clk); #1;
    bus.start = 0;
    while (!got_done && cyc < 4 * l + 40) begin
      if (bus.done) begin
        got_done = 1;
      end else begin
        if (timed && cyc <= 2) check_eq("rd_first_valid", bus.rd_valid, cyc == 2);
        case (mode)
          0:       bus.rd_ready = 1;
          1:       bus.rd_ready = (cyc >= 4 && cyc < 9) ? 1'b0 : cyc[0];
          default: bus.rd_ready = 0;
        endcase
        if (cyc == abort_at) begin
          stall_en = 0;
          bus.abort = 1;
          aborted = 1;
        end
        @(posedge clk); #1;
        bus.abort = 0;
        cyc++;
      end
    end
    check_eq("rd_done_seen", got_done, 1);
    if (got_done) begin
      check_eq("rd_err", bus.err, aborted);
      check_eq("rd_valid_after", bus.rd_valid, 0);
      if (timed) check_eq("rd_cycles", cyc, l + 2);
      if (!aborted) check_eq("rd_q_drained", rd_exp_q.size(), 0);
    end
    bus.rd_ready = 0;
    stall_en = 0;
    $display("read col=%0d len=%0d popped=%0d cycles=%0d err=%0b", c, l, rd_popped, cyc, bus.err);
    rd_exp_q.delete();
    @(posedge clk); #1;
    check_eq("rd_idle_busy", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.dir = 0; bus.col = '0; bus.len = '0; bus.abort = 0;
    bus.wr_data = '0; bus.wr_valid = 0; bus.rd_ready = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_wr_ready", bus.wr_ready, 0);
    check_eq("rst_buf_en", bus.buf_en, 0);
    check_eq("rst_buf_we", bus.buf_we, 0);
    check_eq("rst_rd_data", bus.rd_data, 0);
    reset_n = 1;

    // full page write then read back
    do_write(0, 2048, 8'h00, -1, 0);
    do_read(0, 2048, 0, -1, 1);

    // backpressure
    do_read(100, 10, 1, -1, 0);

    // edge of page
    do_write(2047, 1, 8'h5A, -1, 0);
    check_eq("edge_ram_2047", ram[2047], 8'hA5);
    do_short(2047, 2, 1);

    // zero length and start while busy
    do_short(10, 0, 0);
    do_write(300, 4, 8'h77, -1, 1);

    // aborts
    do_write(0, 16, 8'h3C, 5, 0);
    do_read(0, 16, 2, 6, 0);

    // asynchronous reset in the middle of a read
    for (int i = 0; i < 64; i++) rd_exp_q.push_back(model[i]);
    rd_issued = 0;
    rd_popped = 0;
    stall_en = 1;
    @(posedge clk); #1;
    bus.start = 1; bus.dir = 1; bus.col = '0; bus.len = 12'd64; bus.rd_ready = 1;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (10) @(posedge clk);
    #3;
    check_eq("pre_reset_busy", bus.busy, 1);
    stall_en = 0;
    reset_n = 0;
    #1;
    check_eq("async_rst_busy", bus.busy, 0);
    check_eq("async_rst_rd_valid", bus.rd_valid, 0);
    check_eq("async_rst_done", bus.done, 0);
    check_eq("async_rst_buf_en", bus.buf_en, 0);
    $display("reset asserted mid-read after %0d bytes popped", rd_popped);
    rd_exp_q.delete();
    bus.rd_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1;
    do_read(0, 4, 0, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
